// File: rtl/fetch_predict.sv
// Fetch PC generator with gshare direction predictor and 16-entry direct-mapped BTB.
// Single cycle: prediction is combinational from current PC; EX updates land on the next edge.
module fetch_predict #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        E_redirect,
  input  logic [31:0] E_redirect_PC,
  input  logic        E_update,
  input  logic        E_is_branch,
  input  logic        E_is_jump,
  input  logic        E_taken,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_target,
  input  logic [7:0]  E_addr_PHT,
  output logic [31:0] F_PC_cur,
  output logic [31:0] F_PC_next,
  output logic [1:0]  F_PC_src,
  output logic [31:0] F_PC_target_btb,
  output logic        F_predict,
  output logic [7:0]  F_addr_PHT
);

  logic [31:0] r_pc;
  logic [7:0]  r_ghr;
  logic [1:0]  r_pht [256];
  logic [15:0] r_btb_vld;
  logic [25:0] r_btb_tag [16];
  logic [31:0] r_btb_tgt [16];
  logic        r_btb_jmp [16];

  logic [3:0]  w_btb_idx;
  logic        w_hit;
  logic        w_jmp;
  logic [7:0]  w_pht_idx;
  logic        w_dir_taken;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_nxt;
  logic        w_br_upd;
  logic        w_btb_wr;
  logic [1:0]  w_pht_cur;
  logic [1:0]  w_pht_new;
  logic        w_unused;

  assign w_unused = &{1'b0, E_PC[1:0]};

  // Lookup path
  assign w_btb_idx   = r_pc[5:2];
  assign w_hit       = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == r_pc[31:6]);
  assign w_jmp       = r_btb_jmp[w_btb_idx];
  assign w_pht_idx   = r_pc[9:2] ^ r_ghr;
  assign w_dir_taken = r_pht[w_pht_idx][1];
  assign w_pc_seq    = r_pc + 32'd4;

  assign F_PC_cur        = r_pc;
  assign F_PC_next       = w_pc_seq;
  assign F_addr_PHT      = w_pht_idx;
  assign F_predict       = w_hit && (w_jmp || w_dir_taken);
  assign F_PC_target_btb = w_hit ? r_btb_tgt[w_btb_idx] : 32'h0;

  always_comb begin
    F_PC_src = 2'd0;
    if (w_hit && w_jmp)
      F_PC_src = 2'd2;
    else if (w_hit && w_dir_taken)
      F_PC_src = 2'd1;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (E_redirect)
      w_pc_nxt = E_redirect_PC;
    else if (en)
      w_pc_nxt = F_predict ? r_btb_tgt[w_btb_idx] : w_pc_seq;
  end

  // Update path; a branch+jump combo trains PHT/GHR as a branch and BTB as a jump
  assign w_br_upd  = E_update && E_is_branch;
  assign w_btb_wr  = E_update && E_taken && (E_is_branch || E_is_jump);
  assign w_pht_cur = r_pht[E_addr_PHT];

  always_comb begin
    w_pht_new = w_pht_cur;
    if (E_taken && (w_pht_cur != 2'd3))
      w_pht_new = w_pht_cur + 2'd1;
    else if (!E_taken && (w_pht_cur != 2'd0))
      w_pht_new = w_pht_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ghr     <= 8'h00;
      r_btb_vld <= 16'h0000;
      for (int i = 0; i < 256; i++)
        r_pht[i] <= 2'b01;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_br_upd) begin
        r_ghr             <= {r_ghr[6:0], E_taken};
        r_pht[E_addr_PHT] <= w_pht_new;
      end
      if (w_btb_wr)
        r_btb_vld[E_PC[5:2]] <= 1'b1;
    end
  end

  // Payload needs no reset: it is never observed unless the valid bit is set
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[E_PC[5:2]] <= E_PC[31:6];
      r_btb_tgt[E_PC[5:2]] <= E_target;
      r_btb_jmp[E_PC[5:2]] <= E_is_jump;
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Self-checking bench for fetch_predict: directed scenarios then randomized traffic,
// every cycle compared against an architectural model of PC, history, counters and BTB.
module tb_fetch_predict;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        E_redirect = 1'b0;
  logic [31:0] E_redirect_PC = 32'h0;
  logic        E_update = 1'b0;
  logic        E_is_branch = 1'b0;
  logic        E_is_jump = 1'b0;
  logic        E_taken = 1'b0;
  logic [31:0] E_PC = 32'h0;
  logic [31:0] E_target = 32'h0;
  logic [7:0]  E_addr_PHT = 8'h0;
  logic [31:0] F_PC_cur;
  logic [31:0] F_PC_next;
  logic [1:0]  F_PC_src;
  logic [31:0] F_PC_target_btb;
  logic        F_predict;
  logic [7:0]  F_addr_PHT;

  fetch_predict #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .E_redirect(E_redirect), .E_redirect_PC(E_redirect_PC),
    .E_update(E_update), .E_is_branch(E_is_branch), .E_is_jump(E_is_jump),
    .E_taken(E_taken), .E_PC(E_PC), .E_target(E_target), .E_addr_PHT(E_addr_PHT),
    .F_PC_cur(F_PC_cur), .F_PC_next(F_PC_next), .F_PC_src(F_PC_src),
    .F_PC_target_btb(F_PC_target_btb), .F_predict(F_predict), .F_addr_PHT(F_addr_PHT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural model
  logic [31:0] m_pc;
  logic [7:0]  m_ghr;
  int          m_pht [256];
  bit          m_bv [16];
  logic [25:0] m_btag [16];
  logic [31:0] m_btgt [16];
  bit          m_bj [16];

  task automatic m_reset();
    m_pc  = RESET_PC;
    m_ghr = 8'h00;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
  endtask

  function automatic int m_slot();
    return int'(m_pc[5:2]);
  endfunction

  function automatic bit m_hit();
    return m_bv[m_slot()] && (m_btag[m_slot()] == m_pc[31:6]);
  endfunction

  function automatic logic [7:0] m_index();
    return m_pc[9:2] ^ m_ghr;
  endfunction

  function automatic bit m_dir();
    return m_pht[m_index()] >= 2;
  endfunction

  function automatic bit m_pred();
    return m_hit() && (m_bj[m_slot()] || m_dir());
  endfunction

  task automatic check_outputs();
    int src;
    src = 0;
    if (m_hit()) src = m_bj[m_slot()] ? 2 : (m_dir() ? 1 : 0);
    check_eq("pc_cur", F_PC_cur, m_pc);
    check_eq("pc_next", F_PC_next, m_pc + 32'd4);
    check_eq("pc_src", 32'(F_PC_src), 32'(src));
    check_eq("btb_target", F_PC_target_btb, m_hit() ? m_btgt[m_slot()] : 32'h0);
    check_eq("predict", 32'(F_predict), 32'(m_pred()));
    check_eq("pht_index", 32'(F_addr_PHT), 32'(m_index()));
  endtask

  task automatic m_apply();
    logic [31:0] npc;
    if (E_redirect) npc = E_redirect_PC;
    else if (en) npc = m_pred() ? m_btgt[m_slot()] : m_pc + 32'd4;
    else npc = m_pc;
    if (E_update && E_is_branch) begin
      if (E_taken) m_pht[E_addr_PHT] = (m_pht[E_addr_PHT] + 1 > 3) ? 3 : m_pht[E_addr_PHT] + 1;
      else         m_pht[E_addr_PHT] = (m_pht[E_addr_PHT] - 1 < 0) ? 0 : m_pht[E_addr_PHT] - 1;
      m_ghr = {m_ghr[6:0], E_taken};
    end
    if (E_update && E_taken && (E_is_branch || E_is_jump)) begin
      m_bv[E_PC[5:2]]   = 1'b1;
      m_btag[E_PC[5:2]] = E_PC[31:6];
      m_btgt[E_PC[5:2]] = E_target;
      m_bj[E_PC[5:2]]   = E_is_jump;
    end
    m_pc = npc;
  endtask

  // Compare current outputs, advance one edge, land 1 time unit after it
  task automatic tick();
    check_outputs();
    @(posedge clk);
    m_apply();
    #1;
  endtask

  task automatic idle();
    en = 1'b0; E_redirect = 1'b0; E_update = 1'b0;
    E_is_branch = 1'b0; E_is_jump = 1'b0; E_taken = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    idle();
    E_redirect = 1'b1; E_redirect_PC = pc;
    tick();
    idle();
  endtask

  task automatic resolve(input logic br, input logic jmp, input logic tk,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] idx);
    idle();
    E_update = 1'b1; E_is_branch = br; E_is_jump = jmp; E_taken = tk;
    E_PC = pc; E_target = tgt; E_addr_PHT = idx;
    tick();
    idle();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 m_reset();
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    m_reset();
    #12;
    check_eq("rst_pc_cur", F_PC_cur, RESET_PC);
    check_eq("rst_pc_next", F_PC_next, RESET_PC + 32'd4);
    check_eq("rst_src", 32'(F_PC_src), 32'd0);
    check_eq("rst_predict", 32'(F_predict), 32'd0);
    check_eq("rst_target", F_PC_target_btb, 32'h0);
    check_eq("rst_index", 32'(F_addr_PHT), 32'(RESET_PC[9:2]));
    rst_n = 1'b1;

    // Sequential fetch
    en = 1'b1;
    tick(); check_eq("seq_pc1", F_PC_cur, 32'h4);
    tick(); check_eq("seq_pc2", F_PC_cur, 32'h8);
    tick(); check_eq("seq_pc3", F_PC_cur, 32'hC);
    check_eq("seq_src", 32'(F_PC_src), 32'd0);

    // JAL at 0x40 -> 0x100, trained while PC is redirected onto it
    idle();
    E_update = 1'b1; E_is_jump = 1'b1; E_taken = 1'b1;
    E_PC = 32'h40; E_target = 32'h100; E_addr_PHT = 8'h00;
    E_redirect = 1'b1; E_redirect_PC = 32'h40;
    tick(); idle();
    check_eq("jal_src", 32'(F_PC_src), 32'd2);
    check_eq("jal_predict", 32'(F_predict), 32'd1);
    check_eq("jal_target", F_PC_target_btb, 32'h100);
    en = 1'b1; tick(); idle();
    check_eq("jal_follow", F_PC_cur, 32'h100);

    // Redirect wins over stall and a BTB hit
    redirect_to(32'h40);
    check_eq("redir_hit", 32'(F_predict), 32'd1);
    E_redirect = 1'b1; E_redirect_PC = 32'h200; en = 1'b0;
    tick(); idle();
    check_eq("redir_pc", F_PC_cur, 32'h200);

    // Branch at 0x80: GHR goes 0->1->3, fetch index 0x20^3 = 0x23
    do_reset();
    resolve(1'b1, 1'b0, 1'b1, 32'h80, 32'h20, 8'h23);
    resolve(1'b1, 1'b0, 1'b1, 32'h80, 32'h20, 8'h23);
    redirect_to(32'h80);
    check_eq("br_src", 32'(F_PC_src), 32'd1);
    check_eq("br_target", F_PC_target_btb, 32'h20);
    en = 1'b1; tick(); idle();
    check_eq("br_follow", F_PC_cur, 32'h20);
    resolve(1'b1, 1'b0, 1'b0, 32'h80, 32'h20, 8'h23);
    resolve(1'b1, 1'b0, 1'b0, 32'h80, 32'h20, 8'h23);
    redirect_to(32'h80);
    check_eq("br_nt_src", 32'(F_PC_src), 32'd0);
    check_eq("br_nt_target", F_PC_target_btb, 32'h20);

    // Counter saturates at 3: T,T,T,N leaves it at 2; GHR 0x0E, 0xB4 -> index 0x2D^0x0E = 0x23
    do_reset();
    resolve(1'b1, 1'b0, 1'b1, 32'hB4, 32'h20, 8'h23);
    resolve(1'b1, 1'b0, 1'b1, 32'hB4, 32'h20, 8'h23);
    resolve(1'b1, 1'b0, 1'b1, 32'hB4, 32'h20, 8'h23);
    resolve(1'b1, 1'b0, 1'b0, 32'hB4, 32'h20, 8'h23);
    redirect_to(32'hB4);
    check_eq("sat_hi_src", 32'(F_PC_src), 32'd1);

    // Counter saturates at 0: N,N,T leaves it at 1; GHR 0x01, 0x100 -> index 0x40^0x01 = 0x41
    do_reset();
    resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h300, 8'h41);
    resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h300, 8'h41);
    resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h300, 8'h41);
    redirect_to(32'h100);
    check_eq("sat_lo_src", 32'(F_PC_src), 32'd0);
    check_eq("sat_lo_target", F_PC_target_btb, 32'h300);

    // PC wrap at top of address space
    redirect_to(32'hFFFF_FFFC);
    check_eq("wrap_next", F_PC_next, 32'h0);
    check_eq("wrap_predict", 32'(F_predict), 32'd0);
    en = 1'b1; tick(); idle();
    check_eq("wrap_pc", F_PC_cur, 32'h0);

    // Asynchronous reset mid-cycle drops BTB contents
    redirect_to(32'h100);
    check_eq("pre_rst_target", F_PC_target_btb, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pc", F_PC_cur, RESET_PC);
    m_reset();
    #1 rst_n = 1'b1;
    redirect_to(32'h100);
    check_eq("post_rst_target", F_PC_target_btb, 32'h0);
    redirect_to(32'h40);
    check_eq("post_rst_predict", 32'(F_predict), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      en            = ($urandom_range(0, 3) != 0);
      E_redirect    = ($urandom_range(0, 7) == 0);
      E_redirect_PC = rand_pc();
      E_update      = $urandom_range(0, 1) == 1;
      E_is_branch   = $urandom_range(0, 1) == 1;
      E_is_jump     = ($urandom_range(0, 3) == 0);
      E_taken       = $urandom_range(0, 1) == 1;
      E_PC          = rand_pc();
      E_target      = rand_pc();
      E_addr_PHT    = ($urandom_range(0, 1) == 1) ? m_index() : 8'($urandom_range(0, 255));
      tick();
    end
    idle();
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  fetch advance enable; 0 = stall, PC held.
REQ-005 SHALL have port E_redirect  input  1  EX mispredict/redirect request.
REQ-006 SHALL have port E_redirect_PC  input  32  correct PC on redirect.
REQ-007 SHALL have port E_update  input  1  EX resolved a control-transfer instruction this cycle.
REQ-008 SHALL have port E_is_branch  input  1  resolved instruction is a conditional branch.
REQ-009 SHALL have port E_is_jump  input  1  resolved instruction is an unconditional jump (JAL).
REQ-010 SHALL have port E_taken  input  1  resolved outcome taken.
REQ-011 SHALL have port E_PC  input  32  PC of resolved instruction.
REQ-012 SHALL have port E_target  input  32  resolved target address.
REQ-013 SHALL have port E_addr_PHT  input  8  PHT index carried down the pipeline with that instruction.
REQ-014 SHALL have port F_PC_cur  output  32  current fetch PC.
REQ-015 SHALL have port F_PC_next  output  32  F_PC_cur + 4.
REQ-016 SHALL have port F_PC_src  output  2  0 sequential, 1 predicted-taken branch, 2 BTB-hit jump.
REQ-017 SHALL have port F_PC_target_btb  output  32  BTB target on hit, else 0.
REQ-018 SHALL have port F_predict  output  1  next PC taken from BTB.
REQ-019 SHALL have port F_addr_PHT  output  8  PHT index used for this fetch.

Function
REQ-020 SHALL hold state: 32-bit PC, 8-bit GHR, 256 x 2-bit PHT, 16-entry direct-mapped BTB {valid, tag[25:0], target[31:0], is_jump}.
REQ-021 SHALL compute F_addr_PHT = PC[9:2] XOR GHR, combinationally.
REQ-022 SHALL compute BTB index PC[5:2], tag PC[31:6]; hit = valid AND tag equal.
REQ-023 SHALL drive F_predict = hit AND (is_jump OR PHT[F_addr_PHT][1]).
REQ-024 SHALL drive F_PC_src = 2 if hit AND is_jump; 1 if hit AND NOT is_jump AND PHT bit1; else 0.
REQ-025 SHALL drive F_PC_target_btb = BTB target when hit, 32'h0 when miss (even if hit but predicted not-taken, target still driven).
REQ-026 SHALL compute F_PC_next = PC + 4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-027 SHALL update PC each edge: E_redirect -> E_redirect_PC (regardless of en); else en -> (F_predict ? BTB target : PC+4); else hold.
REQ-028 SHALL update PHT[E_addr_PHT] when E_update AND E_is_branch: taken increments saturating at 3, not-taken decrements saturating at 0.
REQ-029 SHALL update GHR when E_update AND E_is_branch: GHR <= {GHR[6:0], E_taken}; jumps do not shift GHR.
REQ-030 SHALL write BTB[E_PC[5:2]] <= {1, E_PC[31:6], E_target, E_is_jump} when E_update AND E_taken AND (E_is_branch OR E_is_jump); not-taken branches leave BTB unchanged.
REQ-031 SHALL make same-cycle lookups see pre-update PHT/BTB/GHR; updates visible from next cycle.
REQ-032 SHALL ignore E_is_branch/E_is_jump/E_taken when E_update = 0; both E_is_branch and E_is_jump set treated as jump for BTB, branch for PHT/GHR.
REQ-033 SHALL be one-cycle: prediction outputs valid in the same cycle as F_PC_cur, no internal pipelining.

Reset
REQ-034 SHALL on rst_n = 0, asynchronously: PC = RESET_PC, GHR = 0, all BTB valid = 0, all PHT = 2'b01 (weakly not-taken).
REQ-035 SHALL therefore output after reset: F_PC_cur = RESET_PC, F_PC_next = RESET_PC+4, F_PC_src = 0, F_predict = 0, F_PC_target_btb = 0, F_addr_PHT = RESET_PC[9:2].
REQ-036 SHALL abandon any in-flight update coincident with reset assertion; BTB target/tag contents may be left unreset.

Verification
REQ-037 SHALL cover reset then en = 1 for 3 cycles -> F_PC_cur 0x0, 0x4, 0x8, 0xC; F_PC_src = 0.
REQ-038 SHALL cover JAL at 0x40 resolved taken to 0x100 (E_update, E_is_jump, E_taken) -> next fetch of 0x40 gives F_PC_src = 2, F_predict = 1, target 0x100, following PC 0x100.
REQ-039 SHALL cover branch at 0x80 taken twice (PHT 01->10->11) with BTB target 0x20 -> next fetch of 0x80 with matching index gives F_PC_src = 1, next PC 0x20; two not-taken updates -> F_PC_src = 0, F_PC_target_btb still 0x20.
REQ-040 SHALL cover E_redirect = 1, E_redirect_PC = 0x200 with en = 0 and a BTB hit -> PC = 0x200 next cycle.
REQ-041 SHALL cover PC = 0xFFFF_FFFC, en = 1, miss -> F_PC_next = 0, PC becomes 0x0; PHT at 3 taken again stays 3, at 0 not-taken stays 0.
REQ-042 SHALL cover rst_n asserted mid-stream with valid BTB entries -> immediate F_PC_cur = RESET_PC, all subsequent lookups miss until new E_update writes.
